// File: rtl/clk_div_pkg.sv
// Shared constants, types and helpers for the clk_divider_bank slice.
package clk_div_pkg;

    localparam int unsigned DIV_W_DEF       = 32;
    localparam int unsigned DEFAULT_DIV_DEF = 25000000;

    typedef logic [DIV_W_DEF-1:0] div_t;

    function automatic int unsigned ch_idx_w(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/clk_div_channel.sv
// One divider channel: half-period counter, active half-period, divided clock and tick.
// The sync input exists only when CLK_DIV_SYNC_EN is defined.
module clk_div_channel
    import clk_div_pkg::*;
#(
    parameter int unsigned DIV_W       = DIV_W_DEF,
    parameter int unsigned DEFAULT_DIV = DEFAULT_DIV_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
`ifdef CLK_DIV_SYNC_EN
    input  logic             sync,
`endif
    input  logic             apply_req,
    input  logic [DIV_W-1:0] new_hp,
    output logic             applied,
    output logic             clk_div,
    output logic             tick
);

    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] hp_q, hp_d;
    logic             clk_div_q, clk_div_d;
    logic             tick_q, tick_d;
    logic             terminal;

    always_comb begin
        terminal  = (cnt_q == (hp_q - DIV_W'(1)));
        cnt_d     = cnt_q;
        hp_d      = hp_q;
        clk_div_d = clk_div_q;
        tick_d    = 1'b0;
        applied   = 1'b0;
`ifdef CLK_DIV_SYNC_EN
        if (sync) begin
            cnt_d     = '0;
            clk_div_d = 1'b0;
            if (apply_req) begin
                hp_d    = new_hp;
                applied = 1'b1;
            end
        end else
`endif
        if (en) begin
            if (terminal) begin
                cnt_d     = '0;
                clk_div_d = ~clk_div_q;
                tick_d    = 1'b1;
                // New half-period only starts after the current one completes
                if (apply_req) begin
                    hp_d    = new_hp;
                    applied = 1'b1;
                end
            end else begin
                cnt_d = cnt_q + DIV_W'(1);
            end
        end else if (apply_req) begin
            hp_d    = new_hp;
            cnt_d   = '0;
            applied = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q     <= '0;
            hp_q      <= DIV_W'(DEFAULT_DIV);
            clk_div_q <= 1'b0;
            tick_q    <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            hp_q      <= hp_d;
            clk_div_q <= clk_div_d;
            tick_q    <= tick_d;
        end
    end

    assign clk_div = clk_div_q;
    assign tick    = tick_q;

endmodule

// File: rtl/clk_divider_bank.sv
// Bank of programmable 50%-duty clock dividers with a single shared load slot.
// Define CLK_DIV_SYNC_EN to add the bank-wide sync realign input.
module clk_divider_bank
    import clk_div_pkg::*;
#(
    parameter int unsigned  CHANNELS    = 4,
    parameter int unsigned  DIV_W       = DIV_W_DEF,
    parameter int unsigned  DEFAULT_DIV = DEFAULT_DIV_DEF,
    localparam int unsigned CH_W        = ch_idx_w(CHANNELS)
) (
    input  logic                clk,
    input  logic                rst,
`ifdef CLK_DIV_SYNC_EN
    input  logic                sync,
`endif
    input  logic [CHANNELS-1:0] en,
    input  logic                ld_valid,
    output logic                ld_ready,
    input  logic [CH_W-1:0]     ld_ch,
    input  logic [DIV_W-1:0]    ld_div,
    output logic [CHANNELS-1:0] clk_div,
    output logic [CHANNELS-1:0] tick
);

    logic                pend_q, pend_d;
    logic [CH_W-1:0]     pend_ch_q, pend_ch_d;
    logic [DIV_W-1:0]    pend_div_q, pend_div_d;
    logic                ready_q, ready_d;
    logic                ch_in_range;
    logic [CHANNELS-1:0] apply_req;
    logic [CHANNELS-1:0] applied;

    always_comb begin
        ch_in_range = (32'(pend_ch_q) < CHANNELS);
        pend_d      = pend_q;
        pend_ch_d   = pend_ch_q;
        pend_div_d  = pend_div_q;
        // Out-of-range targets are simply dropped on the edge after capture
        if (pend_q && (!ch_in_range || (|applied))) begin
            pend_d = 1'b0;
        end
        if (ld_valid && ready_q) begin
            pend_d     = 1'b1;
            pend_ch_d  = ld_ch;
            pend_div_d = (ld_div == '0) ? DIV_W'(1) : ld_div;
        end
        ready_d = !pend_d;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend_q     <= 1'b0;
            pend_ch_q  <= '0;
            pend_div_q <= '0;
            ready_q    <= 1'b1;
        end else begin
            pend_q     <= pend_d;
            pend_ch_q  <= pend_ch_d;
            pend_div_q <= pend_div_d;
            ready_q    <= ready_d;
        end
    end

    assign ld_ready = ready_q;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        assign apply_req[i] = pend_q && (pend_ch_q == CH_W'(i));

        clk_div_channel #(
            .DIV_W      (DIV_W),
            .DEFAULT_DIV(DEFAULT_DIV)
        ) u_ch (
            .clk      (clk),
            .rst      (rst),
            .en       (en[i]),
`ifdef CLK_DIV_SYNC_EN
            .sync     (sync),
`endif
            .apply_req(apply_req[i]),
            .new_hp   (pend_div_q),
            .applied  (applied[i]),
            .clk_div  (clk_div[i]),
            .tick     (tick[i])
        );
    end

endmodule

// File: tb/tb_clk_divider_bank.sv
// Directed bench for clk_divider_bank: a 4-channel bank (DEFAULT_DIV 5) and a 5-channel bank (DEFAULT_DIV 4).
module tb_clk_divider_bank;
    import clk_div_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] en;
    logic       ld_valid;
    logic       ld_ready;
    logic [1:0] ld_ch;
    div_t       ld_div;
    logic [3:0] clk_div;
    logic [3:0] tick;
`ifdef CLK_DIV_SYNC_EN
    logic       sync;
`endif

    logic [4:0] en5;
    logic       ldv5;
    logic       ready5;
    logic [2:0] ldch5;
    logic [7:0] lddiv5;
    logic [4:0] cd5;
    logic [4:0] tick5;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    logic [3:0] exp_tick_tab [0:5] = '{4'h0, 4'h0, 4'h2, 4'h0, 4'hD, 4'h2};
    logic [3:0] exp_cd_tab   [0:5] = '{4'hF, 4'hF, 4'hD, 4'hD, 4'h0, 4'h2};
    logic [3:0] exp4;

    always #5 clk = ~clk;

    clk_divider_bank #(
        .CHANNELS   (4),
        .DIV_W      (32),
        .DEFAULT_DIV(5)
    ) u_dut (
        .clk     (clk),
        .rst     (rst),
`ifdef CLK_DIV_SYNC_EN
        .sync    (sync),
`endif
        .en      (en),
        .ld_valid(ld_valid),
        .ld_ready(ld_ready),
        .ld_ch   (ld_ch),
        .ld_div  (ld_div),
        .clk_div (clk_div),
        .tick    (tick)
    );

    clk_divider_bank #(
        .CHANNELS   (5),
        .DIV_W      (8),
        .DEFAULT_DIV(4)
    ) u_dut5 (
        .clk     (clk),
        .rst     (rst),
`ifdef CLK_DIV_SYNC_EN
        .sync    (sync),
`endif
        .en      (en5),
        .ld_valid(ldv5),
        .ld_ready(ready5),
        .ld_ch   (ldch5),
        .ld_div  (lddiv5),
        .clk_div (cd5),
        .tick    (tick5)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s @cyc %0d: observed %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic wait_until(input int n);
        while (cyc < n) adv();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst      = 1'b0;
        en       = 4'hF;
        ld_valid = 1'b0;
        ld_ch    = '0;
        ld_div   = '0;
        en5      = 5'h1F;
        ldv5     = 1'b0;
        ldch5    = '0;
        lddiv5   = '0;
`ifdef CLK_DIV_SYNC_EN
        sync     = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        check("rst_clk_div", 32'(clk_div), 32'h0);
        check("rst_tick", 32'(tick), 32'h0);
        check("rst_ready", 32'(ld_ready), 32'h1);
        check("rst_clk_div5", 32'(cd5), 32'h0);
        check("rst_ready5", 32'(ready5), 32'h1);
        rst = 1'b1;
        cyc = 0;

        // Default half-period 5: tick every 5 edges, clk_div toggles there
        for (int e = 1; e <= 10; e++) begin
            adv();
            check("def_tick", 32'(tick), (e % 5 == 0) ? 32'hF : 32'h0);
            check("def_clk_div", 32'(clk_div), (((e / 5) % 2) == 1) ? 32'hF : 32'h0);
        end

        // Load 3 into ch1 while it is mid-count
        wait_until(12);
        ld_valid = 1'b1;
        ld_ch    = 2'd1;
        ld_div   = 32'd3;
        adv();
        check("ld1_ready_acc", 32'(ld_ready), 32'h0);
        ld_valid = 1'b0;
        adv();
        check("ld1_ready_wait", 32'(ld_ready), 32'h0);
        adv();
        check("ld1_ready_free", 32'(ld_ready), 32'h1);
        check("ld1_tick15", 32'(tick), 32'hF);
        check("ld1_cd15", 32'(clk_div), 32'hF);
        for (int k = 0; k < 6; k++) begin
            adv();
            check("ld1_tick", 32'(tick), 32'(exp_tick_tab[k]));
            check("ld1_cd", 32'(clk_div), 32'(exp_cd_tab[k]));
        end

        // Load 0 into ch2 (clamped to 1)
        ld_valid = 1'b1;
        ld_ch    = 2'd2;
        ld_div   = 32'd0;
        adv();
        check("ld2_ready_acc", 32'(ld_ready), 32'h0);
        ld_valid = 1'b0;
        adv();
        adv();
        check("ld2_ready_wait", 32'(ld_ready), 32'h0);
        adv();
        check("ld2_ready_free", 32'(ld_ready), 32'h1);
        check("ld2_tick25", 32'(tick[2]), 32'h1);
        check("ld2_cd25", 32'(clk_div[2]), 32'h1);

        // ch2 at clk/2; ch0 paused for 7 edges with cnt = 2
        for (int e = 26; e <= 37; e++) begin
            adv();
            if (e <= 29) begin
                check("div1_tick2", 32'(tick[2]), 32'h1);
                check("div1_cd2", 32'(clk_div[2]), 32'(e % 2));
            end
            if (e >= 28 && e <= 34) begin
                check("hold_tick0", 32'(tick[0]), 32'h0);
                check("hold_cd0", 32'(clk_div[0]), 32'h1);
            end
            if (e == 35 || e == 36) check("resume_tick0", 32'(tick[0]), 32'h0);
            if (e == 37) begin
                check("resume_tick0_37", 32'(tick[0]), 32'h1);
                check("resume_cd0_37", 32'(clk_div[0]), 32'h0);
            end
            if (e == 27) en = 4'b1110;
            if (e == 34) en = 4'hF;
        end

        // Back-to-back loads to out-of-range ch5 on the 5-channel bank
        wait_until(40);
        ldv5   = 1'b1;
        ldch5  = 3'd5;
        lddiv5 = 8'd1;
        adv();
        check("oor_ready41", 32'(ready5), 32'h0);
        adv();
        check("oor_ready42", 32'(ready5), 32'h1);
        check("oor_tick42", 32'(tick5), 32'h0);
        adv();
        check("oor_ready43", 32'(ready5), 32'h0);
        check("oor_tick43", 32'(tick5), 32'h0);
        ldv5 = 1'b0;
        adv();
        check("oor_ready44", 32'(ready5), 32'h1);
        check("oor_tick44", 32'(tick5), 32'h1F);
        check("oor_cd44", 32'(cd5), 32'h1F);

        // Load 2 into disabled ch4: applies on the next edge
        en5    = 5'h0F;
        ldv5   = 1'b1;
        ldch5  = 3'd4;
        lddiv5 = 8'd2;
        adv();
        check("dis_ready45", 32'(ready5), 32'h0);
        ldv5 = 1'b0;
        adv();
        check("dis_ready46", 32'(ready5), 32'h1);
        en5 = 5'h1F;
        adv();
        adv();
        check("dis_tick48", 32'(tick5), 32'h1F);
        check("dis_cd48", 32'(cd5), 32'h00);
        adv();
        check("dis_tick49", 32'(tick5), 32'h00);
        adv();
        check("dis_tick50", 32'(tick5), 32'h10);
        check("dis_cd50", 32'(cd5), 32'h10);

        // Reset mid-count with a load pending on ch3
        ld_valid = 1'b1;
        ld_ch    = 2'd3;
        ld_div   = 32'd2;
        adv();
        check("pre_rst_ready", 32'(ld_ready), 32'h0);
        ld_valid = 1'b0;
        #3;
        rst = 1'b0;
        #1;
        check("mid_rst_clk_div", 32'(clk_div), 32'h0);
        check("mid_rst_tick", 32'(tick), 32'h0);
        check("mid_rst_ready", 32'(ld_ready), 32'h1);
        check("mid_rst_cd5", 32'(cd5), 32'h0);
        check("mid_rst_tick5", 32'(tick5), 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        cyc = 0;
        for (int e = 1; e <= 5; e++) begin
            adv();
            check("post_rst_tick", 32'(tick), (e == 5) ? 32'hF : 32'h0);
        end

`ifdef CLK_DIV_SYNC_EN
        // ch0 hp 4, ch1 hp 6 at different phases, then realign with sync
        en       = 4'h0;
        ld_valid = 1'b1;
        ld_ch    = 2'd0;
        ld_div   = 32'd4;
        adv();
        ld_valid = 1'b0;
        adv();
        check("sync_ld0_ready", 32'(ld_ready), 32'h1);
        ld_valid = 1'b1;
        ld_ch    = 2'd1;
        ld_div   = 32'd6;
        adv();
        ld_valid = 1'b0;
        adv();
        en = 4'b0010;
        adv();
        en = 4'b0011;
        adv();
        adv();
        adv();
        sync = 1'b1;
        adv();
        check("sync_cd", 32'(clk_div), 32'h0);
        check("sync_tick", 32'(tick), 32'h0);
        sync = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            adv();
            exp4 = (k == 4) ? 4'h1 : (k == 6) ? 4'h2 : 4'h0;
            check("sync_run_tick", 32'(tick), 32'(exp4));
            exp4 = (k < 4) ? 4'h0 : (k < 6) ? 4'h1 : 4'h3;
            check("sync_run_cd", 32'(clk_div), 32'(exp4));
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
